// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - MDIO frame constants, field layout and responder state type
package mdio_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int FRAME_BITS = 32;
    localparam int OP_W       = 2;
    localparam int PHYAD_W    = 5;
    localparam int REGAD_W    = 5;
    localparam int DATA_W     = 16;
    localparam int HDR_W      = OP_W + PHYAD_W + REGAD_W;

    // Header shift register layout after the last REGAD bit has been shifted in
    localparam int OP_LSB    = PHYAD_W + REGAD_W;
    localparam int PHYAD_LSB = REGAD_W;

    // Bit indices (k) that close each frame field
    localparam logic [4:0] K_ST_LAST  = 5'd1;
    localparam logic [4:0] K_HDR_LAST = 5'd13;
    localparam logic [4:0] K_TA_LAST  = 5'd15;
    localparam logic [4:0] K_LAST     = 5'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TA,
        S_RD_DATA,
        S_WR_DATA,
        S_SKIP
    } state_t;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/mdio_mdc_edge.sv
// rtl/mdio_mdc_edge.sv - registers MDC in the clk domain and flags its rising/falling edges
module mdio_mdc_edge (
    input  logic clk,
    input  logic reset,
    input  logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    logic mdc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= mdc;
        end
    end

    assign mdc_rise = mdc & ~mdc_q;
    assign mdc_fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - PHY-side MDIO frame decoder driving a strobed register bank
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int          REG_AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mdc,
    input  logic              mdio_in,
    output logic              mdio_out,
    output logic              mdio_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [15:0]       reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [15:0]       reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    logic mdc_rise;
    logic mdc_fall;

    mdio_mdc_edge u_mdc_edge (
        .clk      (clk),
        .reset    (reset),
        .mdc      (mdc),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    state_t              state;
    logic [4:0]          bit_cnt;
    logic [HDR_W-1:0]    hdr_sr;
    logic [DATA_W-1:0]   in_sr;
    logic [DATA_W-1:0]   out_sr;
    logic                is_rd;
    logic                rd_pend;

    logic [4:0]          k_next;
    logic [HDR_W-1:0]    hdr_next;
    logic [DATA_W-1:0]   in_next;
    logic [1:0]          op_next;
    logic [PHYAD_W-1:0]  phy_next;

    // bit_cnt holds the index of the last sampled bit; k_next is the index of the one being sampled
    assign k_next   = bit_cnt + 5'd1;
    assign hdr_next = {hdr_sr[HDR_W-2:0], mdio_in};
    assign in_next  = {in_sr[DATA_W-2:0], mdio_in};
    assign op_next  = hdr_next[OP_LSB +: OP_W];
    assign phy_next = hdr_next[PHYAD_LSB +: PHYAD_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 5'd0;
            hdr_sr    <= '0;
            in_sr     <= '0;
            out_sr    <= '0;
            is_rd     <= 1'b0;
            rd_pend   <= 1'b0;
            mdio_out  <= 1'b0;
            mdio_oe   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            frame_err <= 1'b0;
            rd_pend   <= reg_rd;
            if (rd_pend) begin
                out_sr <= reg_rdata;
            end

            case (state)
                S_IDLE: begin
                    if (mdc_rise && !mdio_in) begin
                        state   <= S_HDR;
                        busy    <= 1'b1;
                        bit_cnt <= 5'd0;
                    end
                end

                S_HDR: begin
                    if (mdc_rise) begin
                        bit_cnt <= k_next;
                        hdr_sr  <= hdr_next;
                        if (k_next == K_ST_LAST && !mdio_in) begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else if (k_next == K_HDR_LAST) begin
                            if (!op_valid(op_next)) begin
                                frame_err <= 1'b1;
                                state     <= S_SKIP;
                            end else if (phy_next != PHY_ADDR) begin
                                state <= S_SKIP;
                            end else begin
                                reg_addr <= hdr_next[REG_AW-1:0];
                                is_rd    <= (op_next == OP_READ);
                                reg_rd   <= (op_next == OP_READ);
                                state    <= S_TA;
                            end
                        end
                    end
                end

                S_TA: begin
                    if (mdc_rise) begin
                        bit_cnt <= k_next;
                        in_sr   <= in_next;
                        if (k_next == K_TA_LAST) begin
                            if (is_rd) begin
                                state <= S_RD_DATA;
                            end else if ({in_sr[0], mdio_in} != TA_WRITE) begin
                                frame_err <= 1'b1;
                                state     <= S_SKIP;
                            end else begin
                                state <= S_WR_DATA;
                            end
                        end
                    end
                end

                S_RD_DATA: begin
                    if (mdc_rise && bit_cnt != K_LAST) begin
                        bit_cnt <= k_next;
                    end
                    // The controller samples on MDC rise, so each bit is launched on the preceding fall
                    if (mdc_fall) begin
                        if (bit_cnt == K_LAST) begin
                            mdio_oe  <= 1'b0;
                            mdio_out <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            mdio_oe  <= 1'b1;
                            mdio_out <= out_sr[DATA_W-1];
                            out_sr   <= {out_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                S_WR_DATA: begin
                    if (mdc_rise) begin
                        bit_cnt <= k_next;
                        in_sr   <= in_next;
                        if (k_next == K_LAST) begin
                            reg_wdata <= in_next;
                            reg_wr    <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end

                S_SKIP: begin
                    if (mdc_rise) begin
                        bit_cnt <= k_next;
                        if (k_next == K_LAST) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - self-checking bench for mdio_responder with a frame-level reference model
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic        mdio_out;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        busy;
    logic        frame_err;

    mdio_responder #(.PHY_ADDR(5'd1), .REG_AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Behavioural register bank; preload port lets the bench seed contents
    logic [15:0] bank [32];
    logic        bank_ld = 1'b0;
    logic [4:0]  bank_ld_addr = 5'd0;
    logic [15:0] bank_ld_data = 16'd0;

    always @(posedge clk) begin
        if (bank_ld) bank[bank_ld_addr] <= bank_ld_data;
        else if (reg_wr) bank[reg_addr] <= reg_wdata;
        if (reg_rd) reg_rdata <= bank[reg_addr];
    end

    // Reference model state
    logic [15:0] model_bank [32];
    logic [20:0] exp_wr[$];
    logic [4:0]  exp_rd[$];
    int          exp_err = 0;

    // Observed strobes
    logic [20:0] obs_wr[$];
    logic [4:0]  obs_rd[$];
    int          obs_err = 0;
    int          width_bad = 0;
    logic        wr_prev = 1'b0, rd_prev = 1'b0, err_prev = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        if (reg_wr) obs_wr.push_back({reg_addr, reg_wdata});
        if (reg_rd) obs_rd.push_back(reg_addr);
        if (frame_err) obs_err <= obs_err + 1;
        if ((reg_wr && wr_prev) || (reg_rd && rd_prev) || (frame_err && err_prev))
            width_bad <= width_bad + 1;
        wr_prev  <= reg_wr;
        rd_prev  <= reg_rd;
        err_prev <= frame_err;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // One MDC period: fall (launch bit), then rise; responder output sampled between them
    task automatic mdc_cycle(input logic b, output logic o, output logic oe, output logic bz);
        @(posedge clk); #1;
        mdc = 1'b0;
        mdio_in = b;
        @(posedge clk); #1;
        o  = mdio_out;
        oe = mdio_oe;
        bz = busy;
        mdc = 1'b1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bank_ld = 1'b1;
        bank_ld_addr = a;
        bank_ld_data = d;
        @(posedge clk); #1;
        bank_ld = 1'b0;
        model_bank[a] = d;
    endtask

    task automatic send_frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] data,
                              input int gap);
        logic [31:0] word;
        logic        full, drive_rd, o, oe, bz;
        logic [15:0] rx, exp_rx;
        int          oe_bad, busy_bad;
        full     = (st == 2'b01);
        drive_rd = full && (op == 2'b10) && (phy == 5'd1);
        exp_rx   = model_bank[ra];
        if (!full) begin
            exp_err++;
            word = {2'b00, 30'h3FFF_FFFF};
        end else begin
            if (op == 2'b11 || op == 2'b00) exp_err++;
            else if (phy != 5'd1) begin end
            else if (op == 2'b10) exp_rd.push_back(ra);
            else if (ta != 2'b10) exp_err++;
            else begin
                exp_wr.push_back({ra, data});
                model_bank[ra] = data;
            end
            word = (op == 2'b10) ? {st, op, phy, ra, 18'h3FFFF} : {st, op, phy, ra, ta, data};
        end
        oe_bad = 0;
        busy_bad = 0;
        rx = 16'd0;
        for (int i = 0; i < gap; i++) begin
            mdc_cycle(1'b1, o, oe, bz);
            if (oe !== 1'b0) oe_bad++;
            if (bz !== 1'b0) busy_bad++;
        end
        for (int k = 0; k < 32; k++) begin
            mdc_cycle(word[31-k], o, oe, bz);
            if (oe !== (drive_rd && k >= 16)) oe_bad++;
            if (bz !== (full ? (k >= 1) : (k == 1))) busy_bad++;
            if (k >= 16) rx = {rx[14:0], o};
        end
        vectors += 2;
        if (oe_bad != 0) begin
            miscompares++;
            $display("FAIL oe_window frame=%h: %0d bad periods, required 0", word, oe_bad);
        end
        if (busy_bad != 0) begin
            miscompares++;
            $display("FAIL busy_window frame=%h: %0d bad periods, required 0", word, busy_bad);
        end
        if (drive_rd) begin
            vectors++;
            if (rx !== exp_rx) begin
                miscompares++;
                $display("FAIL read_data reg=%0d: got %h, required %h", ra, rx, exp_rx);
            end
        end
    endtask

    task automatic check_events(input string name);
        logic o, oe, bz;
        logic ok;
        mdc_cycle(1'b1, o, oe, bz);
        mdc_cycle(1'b1, o, oe, bz);
        vectors++;
        ok = (obs_wr.size() == exp_wr.size());
        if (ok) foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) ok = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_writes: got %0d writes (last %h), required %0d (last %h)", name,
                     obs_wr.size(), (obs_wr.size() > 0) ? obs_wr[$] : 21'd0,
                     exp_wr.size(), (exp_wr.size() > 0) ? exp_wr[$] : 21'd0);
        end
        vectors++;
        ok = (obs_rd.size() == exp_rd.size());
        if (ok) foreach (exp_rd[i]) if (obs_rd[i] !== exp_rd[i]) ok = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_reads: got %0d reads, required %0d", name, obs_rd.size(), exp_rd.size());
        end
        vectors++;
        if (obs_err != exp_err) begin
            miscompares++;
            $display("FAIL %s_frame_err: got %0d pulses, required %0d", name, obs_err, exp_err);
        end
        vectors++;
        if (width_bad != 0) begin
            miscompares++;
            $display("FAIL %s_strobe_width: got %0d over-long strobes, required 0", name, width_bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({mdio_out, mdio_oe, reg_wr, reg_rd, busy, frame_err, reg_addr, reg_wdata} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {mdio_out, mdio_oe, reg_wr, reg_rd, busy, frame_err, reg_addr, reg_wdata});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; mdc = ~mdc; mdio_in = 1'b0;
        end
        vectors++;
        if ({busy, mdio_oe, frame_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_holds: got %b, required 000", {busy, mdio_oe, frame_err});
        end
        mdio_in = 1'b1;
        mdc = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int a = 0; a < 32; a++) preload(5'(a), 16'($urandom));
    endtask

    task automatic test_write();
        send_frame(2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'hBEEF, 2);
        check_events("write");
    endtask

    task automatic test_read();
        preload(5'd5, 16'hA5C3);
        send_frame(2'b01, 2'b10, 5'd1, 5'd5, 2'b00, 16'h0000, 2);
        check_events("read");
    endtask

    task automatic test_phy_mismatch();
        send_frame(2'b01, 2'b10, 5'd2, 5'd5, 2'b00, 16'h0000, 1);
        send_frame(2'b01, 2'b01, 5'd2, 5'd6, 2'b10, 16'h5555, 0);
        check_events("phy_mismatch");
    endtask

    task automatic test_errors();
        send_frame(2'b01, 2'b11, 5'd1, 5'd7, 2'b10, 16'hDEAD, 1);
        send_frame(2'b01, 2'b01, 5'd1, 5'd8, 2'b10, 16'h1234, 0);
        send_frame(2'b00, 2'b01, 5'd1, 5'd9, 2'b10, 16'hDEAD, 1);
        send_frame(2'b01, 2'b01, 5'd1, 5'd10, 2'b10, 16'h1234, 0);
        send_frame(2'b01, 2'b01, 5'd1, 5'd11, 2'b01, 16'hDEAD, 1);
        send_frame(2'b01, 2'b01, 5'd1, 5'd12, 2'b10, 16'h1234, 0);
        check_events("errors");
    endtask

    task automatic test_reset_midframe();
        logic [31:0] word;
        logic        o, oe, bz;
        preload(5'd0, 16'h0F0F);
        word = {2'b01, 2'b10, 5'd1, 5'd7, 18'h3FFFF};
        exp_rd.push_back(5'd7);
        for (int k = 0; k <= 20; k++) mdc_cycle(word[31-k], o, oe, bz);
        vectors++;
        if (oe !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_driving: mdio_oe=%b before reset, required 1", oe);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({mdio_oe, mdio_out, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL midframe_reset: oe/out/busy=%b, required 000", {mdio_oe, mdio_out, busy});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send_frame(2'b01, 2'b10, 5'd1, 5'd0, 2'b00, 16'h0000, 4);
        check_events("reset_midframe");
    endtask

    task automatic test_back_to_back();
        logic [4:0]  a;
        logic [15:0] d;
        a = 5'($urandom_range(0, 31));
        d = 16'($urandom);
        send_frame(2'b01, 2'b01, 5'd1, a, 2'b10, d, 1);
        send_frame(2'b01, 2'b10, 5'd1, a, 2'b00, 16'h0000, 0);
        send_frame(2'b01, 2'b01, 5'd1, a, 2'b10, ~d, 0);
        send_frame(2'b01, 2'b10, 5'd1, a, 2'b00, 16'h0000, 0);
        check_events("back_to_back");
    endtask

    task automatic test_random();
        logic [1:0] st, op, ta;
        logic [4:0] phy;
        for (int n = 0; n < 40; n++) begin
            st  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
            op  = 2'($urandom_range(0, 3));
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
            ta  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            send_frame(st, op, phy, 5'($urandom_range(0, 31)), ta, 16'($urandom),
                       int'($urandom_range(0, 2)));
        end
        check_events("random");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_phy_mismatch();
        test_errors();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
